// File: rtl/board_pkg.sv
// Shared board definitions: tile encodings, board geometry and the move FSM states.
package board_pkg;

  typedef logic [3:0] tile_t;

  localparam tile_t EMPTY  = 4'd0;
  localparam tile_t WALL   = 4'd1;
  localparam tile_t PELLET = 4'd2;
  localparam tile_t PAC    = 4'd3;
  localparam tile_t GHOST  = 4'd4;

  localparam int BOARD_W = 32;
  localparam int BOARD_H = 24;
  localparam int CELLS   = BOARD_W * BOARD_H;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CHECK,
    ST_CLEAR,
    ST_DRAW,
    ST_RESP
  } move_state_t;

endpackage

// File: rtl/move_commit_unit.sv
// Commits one actor move into the board RAM as a checked read-modify-write,
// and keeps the remaining-pellet count.
module move_commit_unit
  import board_pkg::*;
#(
  parameter int CELLS        = 768,
  parameter int ADDR_W       = 10,
  parameter int TYPE_W       = 4,
  parameter int PELLETS_INIT = 240
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_from,
  input  logic [ADDR_W-1:0] req_to,
  input  logic [TYPE_W-1:0] req_sprite,
  input  logic [TYPE_W-1:0] req_restore,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [TYPE_W-1:0] rd_data,
  output logic              wren,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [TYPE_W-1:0] wr_data,
  output logic              done_valid,
  output logic              done_ok,
  output logic              done_collide,
  output logic [TYPE_W-1:0] done_under,
  output logic [7:0]        pellets_left,
  output logic              level_clear
);

  localparam logic [TYPE_W-1:0] T_WALL   = TYPE_W'(WALL);
  localparam logic [TYPE_W-1:0] T_PELLET = TYPE_W'(PELLET);
  localparam logic [TYPE_W-1:0] T_PAC    = TYPE_W'(PAC);
  localparam logic [TYPE_W-1:0] T_GHOST  = TYPE_W'(GHOST);
  localparam logic [ADDR_W:0]   CELLS_W  = (ADDR_W+1)'(CELLS);
  localparam logic [7:0]        PEL_INIT = 8'(PELLETS_INIT);

  move_state_t       state_q;
  logic [ADDR_W-1:0] from_q, to_q, rd_addr_q, wr_addr_q;
  logic [TYPE_W-1:0] sprite_q, restore_q, wr_data_q, done_under_q;
  logic              wren_q, done_valid_q, done_ok_q, done_collide_q;
  logic [7:0]        pellets_q, pellets_d;
  logic              out_of_range, same_cell, occupied, reject;

  // Range and self-move rejects ignore rd_data entirely, so they never report a collision.
  assign out_of_range = ({1'b0, to_q} >= CELLS_W);
  assign same_cell    = (to_q == from_q);
  assign occupied     = (rd_data == T_PAC) || (rd_data == T_GHOST);
  assign reject       = out_of_range || same_cell || (rd_data == T_WALL) || occupied;

  always_comb begin
    pellets_d = pellets_q;
    if (sprite_q == T_PAC && done_under_q == T_PELLET && pellets_q != 8'd0)
      pellets_d = pellets_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q        <= ST_IDLE;
      from_q         <= '0;
      to_q           <= '0;
      sprite_q       <= '0;
      restore_q      <= '0;
      rd_addr_q      <= '0;
      wren_q         <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      done_valid_q   <= 1'b0;
      done_ok_q      <= 1'b0;
      done_collide_q <= 1'b0;
      done_under_q   <= '0;
      pellets_q      <= PEL_INIT;
    end else begin
      done_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (req_valid) begin
          from_q    <= req_from;
          to_q      <= req_to;
          sprite_q  <= req_sprite;
          restore_q <= req_restore;
          rd_addr_q <= req_to;
          state_q   <= ST_READ;
        end
        ST_READ: state_q <= ST_CHECK;
        ST_CHECK: begin
          done_under_q <= rd_data;
          if (reject) begin
            done_ok_q      <= 1'b0;
            done_collide_q <= !out_of_range && !same_cell && occupied;
            done_valid_q   <= 1'b1;
            state_q        <= ST_RESP;
          end else begin
            wren_q    <= 1'b1;
            wr_addr_q <= from_q;
            wr_data_q <= restore_q;
            state_q   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          wr_addr_q <= to_q;
          wr_data_q <= sprite_q;
          state_q   <= ST_DRAW;
        end
        ST_DRAW: begin
          wren_q         <= 1'b0;
          done_ok_q      <= 1'b1;
          done_collide_q <= 1'b0;
          done_valid_q   <= 1'b1;
          pellets_q      <= pellets_d;
          state_q        <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == ST_IDLE) && !reset;
  assign rd_addr      = rd_addr_q;
  assign wren         = wren_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign done_valid   = done_valid_q;
  assign done_ok      = done_ok_q;
  assign done_collide = done_collide_q;
  assign done_under   = done_under_q;
  assign pellets_left = pellets_q;
  assign level_clear  = (pellets_q == 8'd0);

endmodule

// File: tb/tb_move_commit_unit.sv
// Directed bench for move_commit_unit: two instances (default pellet count and a
// single-pellet board) each backed by a small board RAM model.
module tb_move_commit_unit;
  import board_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       restart = 1'b0;
  logic       req_valid = 1'b0, req_valid1 = 1'b0;
  logic [9:0] req_from = '0, req_to = '0;
  logic [3:0] req_sprite = '0, req_restore = '0;

  logic       req_ready, wren, done_valid, done_ok, done_collide, level_clear;
  logic [9:0] rd_addr, wr_addr;
  logic [3:0] rd_data, wr_data, done_under;
  logic [7:0] pellets_left;

  logic       req_ready1, wren1, done_valid1, done_ok1, done_collide1, level_clear1;
  logic [9:0] rd_addr1, wr_addr1;
  logic [3:0] rd_data1, wr_data1, done_under1;
  logic [7:0] pellets_left1;

  logic       pre_we = 1'b0;
  logic [9:0] pre_addr = '0;
  logic [3:0] pre_data = '0;
  logic [3:0] mem0 [0:1023];
  logic [3:0] mem1 [0:1023];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  move_commit_unit u_dut (
    .clk(clk), .reset(reset), .restart(restart),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_from(req_from), .req_to(req_to), .req_sprite(req_sprite), .req_restore(req_restore),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data),
    .done_valid(done_valid), .done_ok(done_ok), .done_collide(done_collide), .done_under(done_under),
    .pellets_left(pellets_left), .level_clear(level_clear)
  );

  move_commit_unit #(.PELLETS_INIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .restart(restart),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_from(req_from), .req_to(req_to), .req_sprite(req_sprite), .req_restore(req_restore),
    .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wren(wren1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .done_valid(done_valid1), .done_ok(done_ok1), .done_collide(done_collide1), .done_under(done_under1),
    .pellets_left(pellets_left1), .level_clear(level_clear1)
  );

  always @(posedge clk) begin
    if (pre_we) begin
      mem0[pre_addr] <= pre_data;
      mem1[pre_addr] <= pre_data;
    end else begin
      if (wren)  mem0[wr_addr]  <= wr_data;
      if (wren1) mem1[wr_addr1] <= wr_data1;
    end
    rd_data  <= mem0[rd_addr];
    rd_data1 <= mem1[rd_addr1];
  end

  always @(negedge clk) begin
    if (wren) wr_cnt <= wr_cnt + 1;
    if (done_valid) done_cnt <= done_cnt + 1;
  end

  task automatic preload(input logic [9:0] a, input logic [3:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Transfer at the next rising edge; returns at the falling edge of the READ cycle.
  task automatic issue(input logic [9:0] f, input logic [9:0] t, input logic [3:0] s,
                       input logic [3:0] r, input bit sel);
    @(negedge clk);
    req_from = f; req_to = t; req_sprite = s; req_restore = r;
    if (sel) req_valid1 = 1'b1; else req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_valid1 = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %0b want 0", wren); end
    checks++; if (rd_addr !== 10'd0) begin errors++; $display("FAIL rst_rd_addr got %0d want 0", rd_addr); end
    checks++; if (wr_addr !== 10'd0 || wr_data !== 4'd0) begin errors++; $display("FAIL rst_wr got %0d/%0d want 0/0", wr_addr, wr_data); end
    checks++; if ({done_valid, done_ok, done_collide} !== 3'b000 || done_under !== 4'd0) begin errors++; $display("FAIL rst_done got %b/%0d want 000/0", {done_valid, done_ok, done_collide}, done_under); end
    checks++; if (pellets_left !== 8'd240 || level_clear !== 1'b0) begin errors++; $display("FAIL rst_pellets got %0d/%0b want 240/0", pellets_left, level_clear); end
    checks++; if (pellets_left1 !== 8'd1 || level_clear1 !== 1'b0) begin errors++; $display("FAIL rst_pellets1 got %0d/%0b want 1/0", pellets_left1, level_clear1); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_during got %0b want 0", req_ready); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %0b want 1", req_ready); end
  endtask

  task automatic test_accept_pellet;
    int w0;
    preload(10'd496, PELLET);
    w0 = wr_cnt;
    issue(10'd495, 10'd496, PAC, EMPTY, 1'b0);
    checks++; if (req_ready !== 1'b0 || wren !== 1'b0) begin errors++; $display("FAIL acc_read got rdy=%0b wren=%0b want 0/0", req_ready, wren); end
    @(negedge clk);
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL acc_check_wren got %0b want 0", wren); end
    @(negedge clk);
    checks++; if (wren !== 1'b1 || wr_addr !== 10'd495 || wr_data !== 4'd0) begin errors++; $display("FAIL acc_clear got %0b/%0d/%0d want 1/495/0", wren, wr_addr, wr_data); end
    @(negedge clk);
    checks++; if (wren !== 1'b1 || wr_addr !== 10'd496 || wr_data !== 4'd3) begin errors++; $display("FAIL acc_draw got %0b/%0d/%0d want 1/496/3", wren, wr_addr, wr_data); end
    @(negedge clk);
    checks++; if (done_valid !== 1'b1 || done_ok !== 1'b1 || done_collide !== 1'b0 || done_under !== 4'd2) begin errors++; $display("FAIL acc_resp got v=%0b ok=%0b col=%0b und=%0d want 1/1/0/2", done_valid, done_ok, done_collide, done_under); end
    checks++; if (pellets_left !== 8'd239 || wren !== 1'b0) begin errors++; $display("FAIL acc_pellets got %0d wren=%0b want 239/0", pellets_left, wren); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || done_valid !== 1'b0) begin errors++; $display("FAIL acc_idle got rdy=%0b v=%0b want 1/0", req_ready, done_valid); end
    checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL acc_wr_count got %0d want 2", wr_cnt - w0); end
    checks++; if (mem0[495] !== 4'd0 || mem0[496] !== 4'd3) begin errors++; $display("FAIL acc_board got %0d/%0d want 0/3", mem0[495], mem0[496]); end
  endtask

  task automatic test_wall;
    int w0;
    preload(10'd600, WALL);
    w0 = wr_cnt;
    issue(10'd599, 10'd600, PAC, EMPTY, 1'b0);
    @(negedge clk);
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL wall_early_done got %0b want 0", done_valid); end
    @(negedge clk);
    checks++; if (done_valid !== 1'b1 || done_ok !== 1'b0 || done_collide !== 1'b0 || done_under !== 4'd1) begin errors++; $display("FAIL wall_resp got v=%0b ok=%0b col=%0b und=%0d want 1/0/0/1", done_valid, done_ok, done_collide, done_under); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wall_ready_resp got %0b want 0", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wall_ready_after got %0b want 1", req_ready); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL wall_writes got %0d want 0", wr_cnt - w0); end
  endtask

  task automatic test_ghost_collide;
    int w0;
    preload(10'd300, PAC);
    w0 = wr_cnt;
    issue(10'd299, 10'd300, GHOST, PELLET, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (done_valid !== 1'b1 || done_ok !== 1'b0 || done_collide !== 1'b1 || done_under !== 4'd3) begin errors++; $display("FAIL ghost_resp got v=%0b ok=%0b col=%0b und=%0d want 1/0/1/3", done_valid, done_ok, done_collide, done_under); end
    @(negedge clk);
    checks++; if (wr_cnt - w0 !== 0 || pellets_left !== 8'd239) begin errors++; $display("FAIL ghost_side got wr=%0d pel=%0d want 0/239", wr_cnt - w0, pellets_left); end
  endtask

  task automatic test_range_and_self;
    int w0;
    w0 = wr_cnt;
    issue(10'd10, 10'd800, PAC, EMPTY, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (done_valid !== 1'b1 || done_ok !== 1'b0 || done_collide !== 1'b0) begin errors++; $display("FAIL range_resp got v=%0b ok=%0b col=%0b want 1/0/0", done_valid, done_ok, done_collide); end
    @(negedge clk);
    preload(10'd50, EMPTY);
    issue(10'd50, 10'd50, PAC, EMPTY, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (done_valid !== 1'b1 || done_ok !== 1'b0) begin errors++; $display("FAIL self_resp got v=%0b ok=%0b want 1/0", done_valid, done_ok); end
    @(negedge clk);
    checks++; if (wr_cnt - w0 !== 0 || req_ready !== 1'b1) begin errors++; $display("FAIL range_self_side got wr=%0d rdy=%0b want 0/1", wr_cnt - w0, req_ready); end
  endtask

  task automatic test_level_clear;
    preload(10'd200, PELLET);
    preload(10'd201, PELLET);
    issue(10'd199, 10'd200, PAC, EMPTY, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (done_valid1 !== 1'b1 || pellets_left1 !== 8'd0 || level_clear1 !== 1'b1) begin errors++; $display("FAIL clear_first got v=%0b pel=%0d lc=%0b want 1/0/1", done_valid1, pellets_left1, level_clear1); end
    @(negedge clk);
    issue(10'd200, 10'd201, PAC, EMPTY, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (done_ok1 !== 1'b1 || done_under1 !== 4'd2 || pellets_left1 !== 8'd0 || level_clear1 !== 1'b1) begin errors++; $display("FAIL clear_sat got ok=%0b und=%0d pel=%0d lc=%0b want 1/2/0/1", done_ok1, done_under1, pellets_left1, level_clear1); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int d0;
    preload(10'd400, EMPTY);
    issue(10'd399, 10'd400, GHOST, EMPTY, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (wren !== 1'b1) begin errors++; $display("FAIL rmid_clear_wren got %0b want 1", wren); end
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (wren !== 1'b0 || pellets_left !== 8'd240 || req_ready !== 1'b0) begin errors++; $display("FAIL rmid_after got wren=%0b pel=%0d rdy=%0b want 0/240/0", wren, pellets_left, req_ready); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1 || done_cnt !== d0) begin errors++; $display("FAIL rmid_idle got rdy=%0b pulses=%0d want 1/0", req_ready, done_cnt - d0); end
  endtask

  task automatic test_restart_mid;
    int d0;
    preload(10'd100, PELLET);
    issue(10'd99, 10'd100, PAC, EMPTY, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (pellets_left !== 8'd239) begin errors++; $display("FAIL rst2_eat got %0d want 239", pellets_left); end
    preload(10'd410, EMPTY);
    issue(10'd409, 10'd410, GHOST, EMPTY, 1'b0);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    restart = 1'b1;
    @(negedge clk);
    checks++; if (wren !== 1'b0 || pellets_left !== 8'd240 || req_ready !== 1'b1) begin errors++; $display("FAIL restart_after got wren=%0b pel=%0d rdy=%0b want 0/240/1", wren, pellets_left, req_ready); end
    restart = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done_cnt !== d0 || wren !== 1'b0) begin errors++; $display("FAIL restart_quiet got pulses=%0d wren=%0b want 0/0", done_cnt - d0, wren); end
  endtask

  task automatic test_back_to_back;
    int d0;
    preload(10'd620, WALL);
    @(negedge clk);
    req_from = 10'd619; req_to = 10'd620; req_sprite = PAC; req_restore = EMPTY; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_read_ready got %0b want 0", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_check_ready got %0b want 0", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b0 || done_valid !== 1'b1) begin errors++; $display("FAIL busy_resp got rdy=%0b v=%0b want 0/1", req_ready, done_valid); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL busy_idle_ready got %0b want 1", req_ready); end
    req_valid = 1'b0;
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL busy_second_xfer got pulses=%0d want 0", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_accept_pellet();
    test_wall();
    test_ghost_collide();
    test_range_and_self();
    test_level_clear();
    test_reset_mid();
    test_restart_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
